sdram_memtest: RTL and testbench

- Request-side initiator for the sdram controller's burst client interface.
- Fills a region with an address-derived pattern using write bursts, then reads it back with read bursts and compares every word.
- Sits between a debug/control register block and the sdram controller's rd_*/wr_* ports.
- Provides a synthesizable self-test and exercises the full client handshake.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_memtest_if.sv | 40 ++++
 rtl/sdram_memtest.sv | 160 ++++++++++++++++
 tb/tb_sdram_memtest.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants, state encoding and address-derived test pattern for the SDRAM memory tester.
package sdram_pkg;
  localparam int         AWIDTH = 20;
  localparam logic [3:0] BLEN   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BURST,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_DATA,
    S_FINISH
  } mt_state_t;

  function automatic logic [15:0] pattern(input logic [AWIDTH-1:0] a, input logic [15:0] seed);
    return a[15:0] ^ {a[19:16], 12'h000} ^ seed;
  endfunction
endpackage

// File: rtl/sdram_memtest_if.sv
// Control/status and burst-client signals of the memory tester; master is the tester side.
interface sdram_memtest_if;
  import sdram_pkg::*;

  logic              start;
  logic [AWIDTH-1:0] base;
  logic [15:0]       nbursts;
  logic [15:0]       seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [15:0]       err_count;
  logic [AWIDTH-1:0] err_addr;
  logic [15:0]       err_data;

  logic [AWIDTH-1:0] rd_addr;
  logic [3:0]        rd_len;
  logic              rd_req;
  logic              rd_ack;
  logic [15:0]       rd_data;
  logic              rd_rdy;
  logic [AWIDTH-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [3:0]        wr_len;
  logic              wr_req;
  logic              wr_ack;

  modport master (
    input  start, base, nbursts, seed, rd_ack, rd_data, rd_rdy, wr_ack,
    output busy, done, pass, timeout, err_count, err_addr, err_data,
           rd_addr, rd_len, rd_req, wr_addr, wr_data, wr_len, wr_req
  );

  modport slave (
    output start, base, nbursts, seed, rd_ack, rd_data, rd_rdy, wr_ack,
    input  busy, done, pass, timeout, err_count, err_addr, err_data,
           rd_addr, rd_len, rd_req, wr_addr, wr_data, wr_len, wr_req
  );
endinterface

// File: rtl/sdram_memtest.sv
// Burst-write an address-derived pattern over a region, read it back and count mismatches.
// Start to first wr_req is one cycle; a watchdog aborts any handshake that stalls for TIMEOUT cycles.
module sdram_memtest
  import sdram_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input logic            clk,
  input logic            reset,
  sdram_memtest_if.master bus
);
  localparam int                WDW    = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0]    WD_MAX = WDW'(TIMEOUT - 1);
  localparam logic [AWIDTH-1:0] BSTEP  = AWIDTH'(BLEN) + AWIDTH'(1);

  mt_state_t         r_state, w_next;
  logic [AWIDTH-1:0] r_base, r_wr_addr, r_rd_addr, r_err_addr;
  logic [15:0]       r_nbursts, r_bcnt, r_seed, r_wr_data, r_err_count, r_err_data;
  logic [3:0]        r_wcnt, r_rcnt;
  logic [WDW-1:0]    r_wd;
  logic              r_busy, r_done, r_pass, r_timeout;

  logic              w_wr_req, w_rd_req, w_activity, w_wd_hit;
  logic              w_wr_last, w_rd_last, w_mismatch, w_spur_wr, w_spur_rd;
  logic [AWIDTH-1:0] w_wr_cur, w_rd_cur;
  logic [1:0]        w_err_inc;
  logic [16:0]       w_err_sum;
  logic [15:0]       w_err_next;

  assign w_wr_cur   = r_wr_addr + AWIDTH'(r_wcnt);
  assign w_rd_cur   = r_rd_addr + AWIDTH'(r_rcnt);
  assign w_activity = bus.wr_ack | bus.rd_ack | bus.rd_rdy;
  assign w_wd_hit   = (r_wd == WD_MAX) && !w_activity;
  assign w_wr_last  = bus.wr_ack && (r_wcnt == BLEN);
  assign w_rd_last  = bus.rd_rdy && (r_rcnt == BLEN);
  assign w_mismatch = (r_state == S_RD_DATA) && bus.rd_rdy &&
                      (bus.rd_data != pattern(w_rd_cur, r_seed));
  assign w_spur_wr  = bus.wr_ack && (r_state != S_WR_BURST);
  assign w_spur_rd  = bus.rd_rdy && (r_state != S_RD_DATA);

  // Mismatch and spurious handshakes can coincide, so up to two errors land per cycle.
  assign w_err_inc  = {1'b0, w_mismatch} + {1'b0, w_spur_wr} + {1'b0, w_spur_rd};
  assign w_err_sum  = {1'b0, r_err_count} + {15'd0, w_err_inc};
  assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    case (r_state)
      S_IDLE:     if (bus.start) w_next = (bus.nbursts == 16'd0) ? S_FINISH : S_WR_BURST;
      S_WR_BURST: begin
        w_wr_req = 1'b1;
        if (w_wr_last)     w_next = S_WR_GAP;
        else if (w_wd_hit) w_next = S_FINISH;
      end
      S_WR_GAP:   w_next = (r_bcnt == 16'd1) ? S_RD_REQ : S_WR_BURST;
      S_RD_REQ: begin
        w_rd_req = 1'b1;
        if (bus.rd_ack)    w_next = S_RD_DATA;
        else if (w_wd_hit) w_next = S_FINISH;
      end
      S_RD_DATA: begin
        if (w_rd_last)     w_next = (r_bcnt == 16'd1) ? S_FINISH : S_RD_REQ;
        else if (w_wd_hit) w_next = S_FINISH;
      end
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0; r_wr_addr <= '0; r_rd_addr <= '0; r_err_addr <= '0;
      r_nbursts <= '0; r_bcnt <= '0; r_seed <= '0; r_wr_data <= '0;
      r_err_count <= '0; r_err_data <= '0; r_wcnt <= '0; r_rcnt <= '0; r_wd <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_pass <= 1'b0; r_timeout <= 1'b0;
    end else begin
      r_wd        <= (w_activity || (w_next != r_state)) ? '0 : r_wd + 1'b1;
      r_err_count <= w_err_next;
      if (w_mismatch && (r_err_count == 16'd0)) begin
        r_err_addr <= w_rd_cur;
        r_err_data <= bus.rd_data;
      end
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_base      <= bus.base;
          r_nbursts   <= bus.nbursts;
          r_bcnt      <= bus.nbursts;
          r_seed      <= bus.seed;
          r_wr_addr   <= bus.base;
          r_wr_data   <= pattern(bus.base, bus.seed);
          r_wcnt      <= '0;
          r_busy      <= 1'b1;
          r_done      <= 1'b0;
          r_pass      <= 1'b0;
          r_timeout   <= 1'b0;
          r_err_count <= '0;
          r_err_addr  <= '0;
          r_err_data  <= '0;
        end
        S_WR_BURST: begin
          if (bus.wr_ack) begin
            r_wcnt    <= r_wcnt + 4'd1;
            r_wr_data <= pattern(w_wr_cur + AWIDTH'(1), r_seed);
          end else if (w_wd_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_WR_GAP: begin
          r_wr_addr <= r_wr_addr + BSTEP;
          r_bcnt    <= r_bcnt - 16'd1;
          if (r_bcnt == 16'd1) begin
            r_bcnt    <= r_nbursts;
            r_rd_addr <= r_base;
            r_rcnt    <= '0;
          end
        end
        S_RD_REQ: if (!bus.rd_ack && w_wd_hit) r_timeout <= 1'b1;
        S_RD_DATA: begin
          if (bus.rd_rdy) begin
            r_rcnt <= r_rcnt + 4'd1;
            if (w_rd_last) begin
              r_rd_addr <= r_rd_addr + BSTEP;
              r_bcnt    <= r_bcnt - 16'd1;
            end
          end else if (w_wd_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_err_count == 16'd0) && !r_timeout;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.timeout   = r_timeout;
  assign bus.err_count = r_err_count;
  assign bus.err_addr  = r_err_addr;
  assign bus.err_data  = r_err_data;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.rd_len    = BLEN;
  assign bus.rd_req    = w_rd_req;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_len    = BLEN;
  assign bus.wr_req    = w_wr_req;
endmodule

// File: tb/tb_sdram_memtest.sv
// Randomized-latency SDRAM client model with a scoreboard for write stream, read requests and final status.
module tb_sdram_memtest;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdram_memtest_if bus ();
  sdram_memtest dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [15:0] cnt;
    logic [19:0] ea;
    logic [15:0] ed;
  } res_t;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [15:0] mem [0:65535];
  bit          corrupt_en = 0;
  logic [19:0] corrupt_addr = '0;
  bit          ack_en = 1;
  res_t        exp_res [$];
  logic [19:0] exp_wa [$];
  logic [15:0] exp_wd [$];
  logic [19:0] exp_ra [$];

  function automatic logic [15:0] tp(input logic [19:0] a, input logic [15:0] s);
    return a[15:0] ^ {a[19:16], 12'h000} ^ s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [19:0] b, input logic [15:0] n, input logic [15:0] s, input bit to);
    res_t        r;
    logic [19:0] off;
    for (int w = 0; w < 16 * int'(n); w++) begin
      exp_wd.push_back(tp(b + 20'(w), s));
      exp_wa.push_back(b + 20'((w / 16) * 16));
    end
    if (!to) for (int j = 0; j < int'(n); j++) exp_ra.push_back(b + 20'(16 * j));
    r   = '{pass: 1'b1, timeout: 1'b0, cnt: 16'd0, ea: 20'd0, ed: 16'd0};
    off = corrupt_addr - b;
    if (to) begin
      r.pass = 1'b0;
      r.timeout = 1'b1;
    end else if (n != 0 && corrupt_en && int'(off) < 16 * int'(n)) begin
      r.pass = 1'b0;
      r.cnt  = 16'd1;
      r.ea   = corrupt_addr;
      r.ed   = tp(corrupt_addr, s) ^ 16'h0001;
    end
    exp_res.push_back(r);
  endtask

  task automatic start_test(input logic [19:0] b, input logic [15:0] n, input logic [15:0] s, input bit to);
    push_exp(b, n, s, to);
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.nbursts = n; bus.seed = s;
    @(negedge clk);
    bus.start = 1'b0;
    if (n != 0) check("first_wr_req", 32'(bus.wr_req), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!bus.done && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      n_checks++;
      n_errs++;
      $display("FAIL done_wait: got done=0 after %0d cycles, expected done=1", k);
    end
    @(negedge clk);
  endtask

  // Write side of the controller model: acks one word at a time with random gaps.
  initial begin
    int d;
    bus.wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_req) begin
        for (int k = 0; k < 16; k++) begin
          d = $urandom_range(0, 5);
          bus.wr_ack = 1'b0;
          repeat (d) @(negedge clk);
          if (!bus.wr_req) break;
          bus.wr_ack = 1'b1;
          mem[16'(bus.wr_addr + 20'(k))] = bus.wr_data;
          @(negedge clk);
        end
        bus.wr_ack = 1'b0;
      end
    end
  end

  initial begin
    int          d;
    logic [19:0] a, ai;
    bus.rd_ack = 1'b0; bus.rd_rdy = 1'b0; bus.rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.rd_req && ack_en) begin
        d = $urandom_range(0, 5);
        repeat (d) @(negedge clk);
        if (bus.rd_req) begin
          a = bus.rd_addr;
          bus.rd_ack = 1'b1;
          @(negedge clk);
          bus.rd_ack = 1'b0;
          for (int i = 0; i < 16; i++) begin
            d = $urandom_range(0, 5);
            repeat (d) @(negedge clk);
            ai = a + 20'(i);
            bus.rd_rdy  = 1'b1;
            bus.rd_data = mem[ai[15:0]] ^ ((corrupt_en && ai == corrupt_addr) ? 16'h0001 : 16'h0000);
            @(negedge clk);
            bus.rd_rdy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic prev_done;
    res_t r;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.wr_req && bus.wr_ack) begin
        if (exp_wd.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL wr_extra: got unexpected write at %0h, expected none", bus.wr_addr);
        end else begin
          check("wr_data", 32'(bus.wr_data), 32'(exp_wd.pop_front()));
          check("wr_addr", 32'(bus.wr_addr), 32'(exp_wa.pop_front()));
        end
      end
      if (bus.rd_req && bus.rd_ack) begin
        if (exp_ra.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL rd_extra: got unexpected read at %0h, expected none", bus.rd_addr);
        end else check("rd_addr", 32'(bus.rd_addr), 32'(exp_ra.pop_front()));
      end
      if (bus.done && !prev_done) begin
        if (exp_res.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL done_extra: got done=1, expected no completion");
        end else begin
          r = exp_res.pop_front();
          check("pass", 32'(bus.pass), 32'(r.pass));
          check("timeout", 32'(bus.timeout), 32'(r.timeout));
          check("err_count", 32'(bus.err_count), 32'(r.cnt));
          check("err_addr", 32'(bus.err_addr), 32'(r.ea));
          check("err_data", 32'(bus.err_data), 32'(r.ed));
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    int          cnt;
    logic [19:0] b;
    logic [15:0] n;
    bus.start = 1'b0; bus.base = '0; bus.nbursts = '0; bus.seed = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pass", 32'(bus.pass), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_wr_req", 32'(bus.wr_req), 32'd0);
    check("rst_rd_req", 32'(bus.rd_req), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_addr", 32'(bus.wr_addr | bus.rd_addr | bus.err_addr), 32'd0);
    reset = 1'b0;

    start_test(20'h00000, 16'd4, 16'h0000, 1'b0);
    wait_done(20000);

    corrupt_en = 1; corrupt_addr = 20'h00023;
    start_test(20'h00000, 16'd4, 16'h0000, 1'b0);
    wait_done(20000);
    corrupt_en = 0;

    start_test(20'hFFFF8, 16'd1, 16'hA5A5, 1'b0);
    wait_done(20000);

    // Empty region: completes two cycles after start with no requests.
    start_test(20'h12345, 16'd0, 16'h1111, 1'b0);
    check("zero_done_early", 32'(bus.done | bus.wr_req | bus.rd_req), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_pass", 32'(bus.pass), 32'd1);
    @(negedge clk);

    ack_en = 0;
    start_test(20'h00100, 16'd1, 16'h3C3C, 1'b1);
    cnt = 0;
    while (!bus.rd_req && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (bus.rd_req && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("rd_req_hold", 32'(cnt), 32'd1024);
    wait_done(3000);
    ack_en = 1;

    b = 20'($urandom);
    start_test(b, 16'd2, 16'($urandom), 1'b0);
    repeat (8) @(negedge clk);
    check("pre_reset_wr_req", 32'(bus.wr_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_wr_req", 32'(bus.wr_req), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    exp_wd.delete(); exp_wa.delete(); exp_ra.delete(); exp_res.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    start_test(20'h0ABC0, 16'd2, 16'h5A5A, 1'b0);
    wait_done(20000);

    for (int t = 0; t < 4; t++) begin
      b = 20'($urandom);
      n = 16'($urandom_range(1, 3));
      corrupt_en   = ($urandom_range(0, 1) == 1);
      corrupt_addr = b + 20'($urandom_range(0, 16 * int'(n) - 1));
      start_test(b, n, 16'($urandom), 1'b0);
      wait_done(20000);
    end
    corrupt_en = 0;

    check("wr_queue_left", 32'(exp_wd.size()), 32'd0);
    check("rd_queue_left", 32'(exp_ra.size()), 32'd0);
    check("res_queue_left", 32'(exp_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
